// File: rtl/pr3_pkg.sv
// Shared types and defaults for the PR3 phase-processing chain.
package pr3_pkg;

    localparam int PHASE_WIDTH_DEFAULT = 16;

    typedef logic        [PHASE_WIDTH_DEFAULT-1:0] phase_t;
    typedef logic signed [PHASE_WIDTH_DEFAULT-1:0] dphase_t;

    typedef enum logic [1:0] {
        COLLECT,
        ACCUM,
        OUTPUT
    } state_t;

endpackage

// File: rtl/phase_capture.sv
// Per-antenna phase holding register with arrival flag and overrun detection.
module phase_capture
    import pr3_pkg::*;
#(
    parameter int W = PHASE_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] phase,
    input  logic         valid,
    input  logic         clear,
    output logic [W-1:0] q,
    output logic         flag,
    output logic         overrun
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            flag    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // An arrival in the clearing cycle starts the next set, so it is not an overrun.
            overrun <= valid & flag & ~clear;
            if (valid) begin
                q    <= phase;
                flag <= 1'b1;
            end else if (clear) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_diff_accum.sv
// Wrapped phase differences (ant2-ant1, ant3-ant1) averaged over RUNS complete sets.
module phase_diff_accum
    import pr3_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEFAULT,
    parameter int RUNS        = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PHASE_WIDTH-1:0] phase1,
    input  logic                   phase1_valid,
    input  logic [PHASE_WIDTH-1:0] phase2,
    input  logic                   phase2_valid,
    input  logic [PHASE_WIDTH-1:0] phase3,
    input  logic                   phase3_valid,
    output logic [PHASE_WIDTH-1:0] diff12,
    output logic [PHASE_WIDTH-1:0] diff13,
    output logic                   out_valid,
    output logic                   overrun
);

    localparam int LOG2 = $clog2(RUNS);
    localparam int AW   = PHASE_WIDTH + LOG2;
    localparam int CW   = (LOG2 > 0) ? LOG2 : 1;

    if ((RUNS < 1) || ((RUNS & (RUNS - 1)) != 0)) begin : g_bad_runs
        $error("phase_diff_accum: RUNS must be a power of 2 and at least 1");
    end

    state_t state, next_state;

    logic [PHASE_WIDTH-1:0] q1, q2, q3;
    logic [2:0]             flag;
    logic [2:0]             ovr;
    logic                   clear;

    logic [CW-1:0]          run_cnt;
    logic                   last_run;

    logic signed [PHASE_WIDTH-1:0] d12s, d13s;
    logic signed [AW-1:0]          acc12, acc13;
    logic signed [AW-1:0]          sum12, sum13;

    assign clear = (state == ACCUM);

    phase_capture #(.W(PHASE_WIDTH)) u_cap1 (
        .clk(clk), .reset(reset), .phase(phase1), .valid(phase1_valid),
        .clear(clear), .q(q1), .flag(flag[0]), .overrun(ovr[0])
    );

    phase_capture #(.W(PHASE_WIDTH)) u_cap2 (
        .clk(clk), .reset(reset), .phase(phase2), .valid(phase2_valid),
        .clear(clear), .q(q2), .flag(flag[1]), .overrun(ovr[1])
    );

    phase_capture #(.W(PHASE_WIDTH)) u_cap3 (
        .clk(clk), .reset(reset), .phase(phase3), .valid(phase3_valid),
        .clear(clear), .q(q3), .flag(flag[2]), .overrun(ovr[2])
    );

    assign overrun  = |ovr;
    assign last_run = (run_cnt == CW'(RUNS - 1));

    // Modular subtraction reinterpreted as signed; sign-extended into the accumulators.
    assign d12s  = q2 - q1;
    assign d13s  = q3 - q1;
    assign sum12 = acc12 + AW'(d12s);
    assign sum13 = acc13 + AW'(d13s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (&flag) next_state = ACCUM;
            ACCUM:   next_state = last_run ? OUTPUT : COLLECT;
            OUTPUT:  next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc12     <= '0;
            acc13     <= '0;
            run_cnt   <= '0;
            diff12    <= '0;
            diff13    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    acc12   <= sum12;
                    acc13   <= sum13;
                    run_cnt <= last_run ? '0 : run_cnt + CW'(1);
                end
                OUTPUT: begin
                    diff12    <= PHASE_WIDTH'(acc12 >>> LOG2);
                    diff13    <= PHASE_WIDTH'(acc13 >>> LOG2);
                    out_valid <= 1'b1;
                    acc12     <= '0;
                    acc13     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_diff_accum.sv
// Bench for phase_diff_accum: three instances (RUNS=1,2,4) on shared stimulus vs a timestamp-scheduling model.
module tb_phase_diff_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] phase1, phase2, phase3;
    logic        phase1_valid, phase2_valid, phase3_valid;

    logic [15:0] d12_o [3];
    logic [15:0] d13_o [3];
    logic        ov_o  [3];
    logic        or_o  [3];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        phase_diff_accum #(.PHASE_WIDTH(16), .RUNS(1 << g)) dut (
            .clk(clk), .reset(reset),
            .phase1(phase1), .phase1_valid(phase1_valid),
            .phase2(phase2), .phase2_valid(phase2_valid),
            .phase3(phase3), .phase3_valid(phase3_valid),
            .diff12(d12_o[g]), .diff13(d13_o[g]),
            .out_valid(ov_o[g]), .overrun(or_o[g])
        );
    end

    // Reference model: each instance tracks which phases have arrived, and the
    // edge numbers at which the pending set will be accumulated / output.
    int          runs_of [3] = '{1, 2, 4};
    int          t = 0;
    bit          have   [3][3];
    int unsigned pv     [3][3];
    int          acc_at [3];
    int          out_at [3];
    int          done   [3];
    longint      s12    [3];
    longint      s13    [3];
    logic        e_ov   [3];
    logic        e_or   [3];
    logic [15:0] e_d12  [3];
    logic [15:0] e_d13  [3];

    function automatic int sdiff(int unsigned a, int unsigned b);
        int d;
        d = int'((a - b) & 32'hFFFF);
        return (d >= 32768) ? d - 65536 : d;
    endfunction

    function automatic logic [15:0] favg(longint s, int r);
        longint a;
        a = (s >= 0) ? s / r : -((-s + r - 1) / r);
        return a[15:0];
    endfunction

    task automatic model_reset(int k);
        for (int i = 0; i < 3; i++) begin
            have[k][i] = 1'b0;
            pv[k][i]   = 0;
        end
        acc_at[k] = -1; out_at[k] = -1; done[k] = 0;
        s12[k] = 0; s13[k] = 0;
        e_ov[k] = 1'b0; e_or[k] = 1'b0; e_d12[k] = '0; e_d13[k] = '0;
    endtask

    task automatic model_edge(bit rst, bit v [3], int unsigned p [3]);
        bit all3, busy, clearing;
        t++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                model_reset(k);
            end else begin
                all3     = have[k][0] && have[k][1] && have[k][2];
                clearing = (acc_at[k] == t);
                busy     = clearing || (out_at[k] == t);
                e_or[k]  = 1'b0;
                e_ov[k]  = 1'b0;
                for (int i = 0; i < 3; i++)
                    if (v[i] && have[k][i] && !clearing) e_or[k] = 1'b1;
                if (clearing) begin
                    s12[k] += sdiff(pv[k][1], pv[k][0]);
                    s13[k] += sdiff(pv[k][2], pv[k][0]);
                    for (int i = 0; i < 3; i++) have[k][i] = 1'b0;
                    done[k]++;
                    if (done[k] == runs_of[k]) begin
                        done[k]   = 0;
                        out_at[k] = t + 1;
                    end
                end
                if (out_at[k] == t) begin
                    e_d12[k] = favg(s12[k], runs_of[k]);
                    e_d13[k] = favg(s13[k], runs_of[k]);
                    e_ov[k]  = 1'b1;
                    s12[k] = 0; s13[k] = 0;
                end
                if (!busy && all3) acc_at[k] = t + 1;
                for (int i = 0; i < 3; i++)
                    if (v[i]) begin
                        have[k][i] = 1'b1;
                        pv[k][i]   = p[i];
                    end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t%0d out_valid[R%0d]", t, runs_of[k]), 32'(ov_o[k]),  32'(e_ov[k]));
            chk($sformatf("t%0d overrun[R%0d]",   t, runs_of[k]), 32'(or_o[k]),  32'(e_or[k]));
            chk($sformatf("t%0d diff12[R%0d]",    t, runs_of[k]), 32'(d12_o[k]), 32'(e_d12[k]));
            chk($sformatf("t%0d diff13[R%0d]",    t, runs_of[k]), 32'(d13_o[k]), 32'(e_d13[k]));
        end
    endtask

    task automatic step(bit rst, bit v1, int unsigned p1, bit v2, int unsigned p2,
                        bit v3, int unsigned p3);
        bit          v [3];
        int unsigned p [3];
        v = '{v1, v2, v3};
        p = '{p1 & 32'hFFFF, p2 & 32'hFFFF, p3 & 32'hFFFF};
        reset = rst;
        phase1_valid = v1; phase1 = p[0][15:0];
        phase2_valid = v2; phase2 = p[1][15:0];
        phase3_valid = v3; phase3 = p[2][15:0];
        @(posedge clk);
        model_edge(rst, v, p);
        #1;
        compare_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic full_set(int unsigned p1, int unsigned p2, int unsigned p3);
        step(0, 1, p1, 1, p2, 1, p3);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset diff12", 32'(d12_o[0]), 32'h0);
        chk("reset out_valid", 32'(ov_o[2]), 32'h0);

        // Basic set, RUNS=1 output three edges after capture.
        full_set(16'h0000, 16'h4000, 16'hC000);
        idle(2);
        chk("basic no early out", 32'(ov_o[0]), 32'h0);
        idle(1);
        chk("basic out_valid", 32'(ov_o[0]), 32'h1);
        chk("basic diff12", 32'(d12_o[0]), 32'h4000);
        chk("basic diff13", 32'(d13_o[0]), 32'hC000);

        // Wrap-around difference.
        full_set(16'hF000, 16'h1000, 16'hE000);
        idle(3);
        chk("wrap diff12", 32'(d12_o[0]), 32'h2000);
        chk("wrap diff13", 32'(d13_o[0]), 32'hF000);
        chk("wrap overrun", 32'(or_o[0]), 32'h0);

        // Four-set average for RUNS=4.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            full_set(16'h1000, 16'h1000 + s * 16'h0100, 16'h0FFF);
            idle(2);
            if (s < 4) chk("avg4 no early out", 32'(ov_o[2]), 32'h0);
        end
        idle(1);
        chk("avg4 out_valid", 32'(ov_o[2]), 32'h1);
        chk("avg4 diff12", 32'(d12_o[2]), 32'h0280);
        chk("avg4 diff13", 32'(d13_o[2]), 32'hFFFF);

        // Staggered arrival with a repeated phase1.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c <= 12; c++) begin
            step(0, (c == 5) || (c == 7), (c == 5) ? 16'h1111 : 16'h2222,
                 c == 9, 16'h5000, c == 0, 16'h9000);
            if (c == 7)  chk("stagger overrun", 32'(or_o[0]), 32'h1);
            if (c == 11) chk("stagger no early out", 32'(ov_o[0]), 32'h0);
        end
        chk("stagger out_valid", 32'(ov_o[0]), 32'h1);
        chk("stagger diff12", 32'(d12_o[0]), 32'h2DDE);
        chk("stagger diff13", 32'(d13_o[0]), 32'h6DDE);

        // New phase1 in the accumulate cycle belongs to the next set.
        step(1, 0, 0, 0, 0, 0, 0);
        full_set(16'h1000, 16'h1100, 16'h0F00);
        idle(1);
        step(0, 1, 16'h2000, 0, 0, 0, 0);
        chk("clrset overrun", 32'(or_o[0]), 32'h0);
        idle(1);
        chk("clrset first diff12", 32'(d12_o[0]), 32'h0100);
        step(0, 0, 0, 1, 16'h2300, 1, 16'h1F00);
        idle(3);
        chk("clrset second out_valid", 32'(ov_o[0]), 32'h1);
        chk("clrset second diff12", 32'(d12_o[0]), 32'h0300);
        chk("clrset second diff13", 32'(d13_o[0]), 32'hFF00);

        // Reset in the middle of the second set of a RUNS=2 pair.
        step(1, 0, 0, 0, 0, 0, 0);
        full_set(16'h0000, 16'h0400, 16'h0100);
        idle(2);
        step(0, 1, 16'h0100, 1, 16'h0200, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        chk("midreset out_valid", 32'(ov_o[1]), 32'h0);
        chk("midreset diff12", 32'(d12_o[1]), 32'h0);
        full_set(16'h1000, 16'h1200, 16'h0E00);
        idle(2);
        full_set(16'h2000, 16'h2400, 16'h1E00);
        idle(3);
        chk("midreset pair out_valid", 32'(ov_o[1]), 32'h1);
        chk("midreset pair diff12", 32'(d12_o[1]), 32'h0300);
        chk("midreset pair diff13", 32'(d13_o[1]), 32'hFE00);

        // Randomized traffic including back-to-back valids and occasional resets.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(2) == 0, $urandom,
                 $urandom_range(2) == 0, $urandom,
                 $urandom_range(2) == 0, $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            step(0, 1, $urandom, 1, $urandom, 1, $urandom);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/phase_diff_accum.md
Name: phase_diff_accum

Overview:
- Sits directly downstream of the three phase_extract instances in PR3, one per antenna.
- Collects one phase value per antenna, computes the wrapped phase differences antenna2−antenna1 and antenna3−antenna1, and averages each over RUNS complete sets.
- Emits a one-cycle-valid result pair for the direction-finding logic.
- Single clock domain: the main clk shared with phase_extract.

Parameters:
- PHASE_WIDTH, 16: phase width in bits; phase format UQ0.PHASE_WIDTH in turns, i.e. [0,1) turn.
- RUNS, 1: number of phase sets averaged per output; must be a power of 2 and ≥1. Checked by an elaboration-time assertion.

Ports:
- clk  in  1  main processing clock.
- reset  in  1  synchronous reset, active-high.
- phase1  in  PHASE_WIDTH  antenna #1 phase (UQ0.PHASE_WIDTH).
- phase1_valid  in  1  phase1 qualifier, single-cycle pulse.
- phase2  in  PHASE_WIDTH  antenna #2 phase (UQ0.PHASE_WIDTH).
- phase2_valid  in  1  phase2 qualifier.
- phase3  in  PHASE_WIDTH  antenna #3 phase (UQ0.PHASE_WIDTH).
- phase3_valid  in  1  phase3 qualifier.
- diff12  out  PHASE_WIDTH  averaged phase2−phase1 (Q1.(PHASE_WIDTH−1) turns, range [−0.5,0.5)).
- diff13  out  PHASE_WIDTH  averaged phase3−phase1 (same format).
- out_valid  out  1  one-cycle pulse; diff12/diff13 are valid while high.
- overrun  out  1  one-cycle pulse: a channel delivered a second phase before its set completed.

Behaviour:
- Reset (synchronous, active-high, dominant over all other events):
  - All outputs 0; capture flags and phase registers 0; accumulators 0; run counter 0; state COLLECT.
  - A reset mid-set or mid-accumulation discards all partial data; no out_valid follows.
- Capture, per channel, independent of state:
  - phaseN_valid=1 at an edge → register phaseN, set flagN.
  - If flagN is already set, overwrite with the new value and pulse overrun the next cycle.
  - Valids may arrive in any order, in any cycle, simultaneously or staggered.
- States: COLLECT → ACCUM → (OUTPUT | COLLECT) → COLLECT.
  - COLLECT: wait until flag1&flag2&flag3. At the first edge where all three are set, go to ACCUM.
  - ACCUM (exactly one cycle):
    - d12 = phase2−phase1 mod 2^PHASE_WIDTH; d13 = phase3−phase1 mod 2^PHASE_WIDTH. Both are reinterpreted as signed.
    - Sign-extend into accumulators of width PHASE_WIDTH+log2(RUNS) and add.
    - Clear all three flags. A valid arriving in the same ACCUM cycle wins over the clear: it sets the flag for the next set and is not an overrun.
    - Increment the run counter. If the counter was RUNS−1, wrap it to 0 and go to OUTPUT; else go to COLLECT.
  - OUTPUT (exactly one cycle):
    - diff12/diff13 ← accumulator >>> log2(RUNS), arithmetic shift (rounds toward −∞), low PHASE_WIDTH bits.
    - Assert out_valid for the next cycle; clear the accumulators.
    - Captures keep running during this state. Go to COLLECT.
- Latency:
  - out_valid rises 3 edges after the edge that captured the last phase of the final set (capture edge E, all-flags detected E+1, ACCUM/accumulate E+2, output registered E+3).
  - For RUNS>1, non-final sets produce no output.
- Outputs hold their last value between pulses.
- Wrap rule: differences never saturate. Modular subtraction is exact, e.g. 0x1000−0xF000 = 0x2000. Averaging differences straddling ±0.5 turn is out of scope; the caller guarantees the spread is well below 0.5 turn.
- Throughput: one set per 3 cycles minimum. Back-to-back valids on every channel every cycle produce overrun pulses, as specified above.

Decomposition:
- Package pr3_pkg:
  - localparam PHASE_WIDTH_DEFAULT=16.
  - typedef phase_t (logic [PHASE_WIDTH-1:0]) and dphase_t (signed, same width).
  - enum state_t {COLLECT, ACCUM, OUTPUT}.
- Sub-module phase_capture: phase register, flag, overrun detect and the clear-vs-set priority. Instantiated three times.
- The top holds the FSM, the subtractors, the accumulators and the output registers.

Test Plan:
- PHASE_WIDTH=16, RUNS=1; phases 0x0000, 0x4000, 0xC000 valid in the same cycle → out_valid 3 edges later, diff12=0x4000, diff13=0xC000.
- Wrap: phase1=0xF000, phase2=0x1000, phase3=0xE000 → diff12=0x2000, diff13=0xF000; overrun stays 0.
- RUNS=4; four sets with d12 = 0x0100, 0x0200, 0x0300, 0x0400 and d13 = −0x0001 each → exactly one out_valid, diff12=0x0280, diff13=0xFFFF; no pulse after sets 1–3.
- Staggered arrival: valid3 at cycle 0, valid1 at cycle 5, valid2 at cycle 9 → out_valid at edge 12. A second valid1 at cycle 7 → overrun pulse at cycle 8, and the later phase1 value is used.
- Same-cycle clear/set: a new valid1 lands in the ACCUM cycle → counted toward the next set, no overrun; the next set completes once valid2 and valid3 arrive.
- Reset asserted one cycle after two of three valids (RUNS=2, mid second set) → all outputs 0, no out_valid. A fresh full set pair afterwards yields the correct average.
